// File: rtl/rgb_mem_arbiter.sv
// Two-requester arbiter for the R/G/B colour planes. Each grant gives one requester all three
// planes for one cycle. Define ARB_RR_EN for round-robin arbitration instead of fixed priority.
module rgb_mem_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [2:0]            m0_wr,
  input  logic [3*ADDR_W-1:0]   m0_addr,
  input  logic [3*DATA_W-1:0]   m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [3*DATA_W-1:0]   m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [2:0]            m1_wr,
  input  logic [3*ADDR_W-1:0]   m1_addr,
  input  logic [3*DATA_W-1:0]   m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [3*DATA_W-1:0]   m1_rdata,

  output logic [2:0]            mem_wr,
  output logic [3*ADDR_W-1:0]   mem_addr,
  output logic [3*DATA_W-1:0]   mem_wdata,
  input  logic [3*DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any_gnt;
  logic [2:0]            w_sel_wr;
  logic [3*ADDR_W-1:0]   w_sel_addr;
  logic [3*DATA_W-1:0]   w_sel_wdata;

  logic [2:0]            r_mem_wr;
  logic [3*ADDR_W-1:0]   r_mem_addr;
  logic [3*DATA_W-1:0]   r_mem_wdata;
  logic [1:0]            r_tag_s1;
  logic [1:0]            r_rvalid;

`ifdef ARB_RR_EN
  // Set when m1 holds the higher priority for the next contested cycle.
  logic                  r_rr_fav1;
`else
  logic [7:0]            r_wait_cnt;
  logic [7:0]            w_wait_nxt;
  logic                  w_starve;

  assign w_starve = (r_wait_cnt == 8'(MAX_WAIT));
`endif

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      StArb: begin
`ifdef ARB_RR_EN
        if (m0_req && m1_req) begin
          w_gnt0 = ~r_rr_fav1;
          w_gnt1 = r_rr_fav1;
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
`else
        if (m1_req && (w_starve || !m0_req)) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = m0_req;
        end
`endif
        if (w_gnt0 && m0_lock) begin
          w_state_nxt = StLock0;
        end else if (w_gnt1 && m1_lock) begin
          w_state_nxt = StLock1;
        end
      end
      StLock0: begin
        w_gnt0 = m0_req;
        if (!m0_req || !m0_lock) begin
          w_state_nxt = StArb;
        end
      end
      StLock1: begin
        w_gnt1 = m1_req;
        if (!m1_req || !m1_lock) begin
          w_state_nxt = StArb;
        end
      end
      default: begin
        w_state_nxt = StArb;
      end
    endcase
    if (reset) begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = StArb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StArb;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_fav1 <= 1'b0;
    end else if (w_gnt0) begin
      r_rr_fav1 <= 1'b1;
    end else if (w_gnt1) begin
      r_rr_fav1 <= 1'b0;
    end
  end
`else
  // Counts consecutive denied cycles of m1; the lock states keep counting but never override.
  always_comb begin
    w_wait_nxt = 8'd0;
    if (m1_req && !w_gnt1) begin
      w_wait_nxt = w_starve ? r_wait_cnt : r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end
`endif

  assign w_any_gnt   = w_gnt0 | w_gnt1;
  assign w_sel_wr    = w_gnt1 ? m1_wr    : m0_wr;
  assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;

  // Address and write data hold across idle cycles; only the write enables drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_wr    <= 3'b000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_wr <= w_any_gnt ? w_sel_wr : 3'b000;
      if (w_any_gnt) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  // Owner tags follow each access through the memory's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_s1 <= 2'b00;
      r_rvalid <= 2'b00;
    end else begin
      r_tag_s1 <= {w_gnt1, w_gnt0};
      r_rvalid <= r_tag_s1;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_rgb_mem_arbiter.sv
// Randomised and directed bench for rgb_mem_arbiter against a transaction-level model with a
// three-plane memory behind the DUT.
module tb_rgb_mem_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m0_req = 1'b0, m0_lock = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [2:0] m0_wr = '0, m1_wr = '0;
  logic [3*AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [3*DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [3*DW-1:0] m0_rdata, m1_rdata;
  logic [2:0] mem_wr;
  logic [3*AW-1:0] mem_addr;
  logic [3*DW-1:0] mem_wdata;
  logic [3*DW-1:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  rgb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single-port planes with one-cycle read latency.
  logic [7:0] env_mem [3][16384];
  always @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      mem_rdata[p*DW +: DW] <= env_mem[p][mem_addr[p*AW +: AW]];
      if (mem_wr[p]) env_mem[p][mem_addr[p*AW +: AW]] <= mem_wdata[p*DW +: DW];
    end
  end

  // Transaction-level model: who owns the bus, how long m1 has waited, and what each
  // granted access must return two cycles later.
  typedef struct {
    bit v;
    bit who;
    logic [2:0] wr;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [3*DW-1:0] rd;
  } acc_t;

  logic [7:0] shadow [3][16384];
  int owner;      // -1: arbitrate, 0/1: locked to that requester
  int waited;
  bit rr_m1_next;
  acc_t p1, p2, nw;
  acc_t empty_acc;
  logic [3*AW-1:0] e_addr;
  logic [3*DW-1:0] e_wdata;
  logic [3*DW-1:0] mask;
  bit mg0, mg1;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
      chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
      chk("rst_mem_wr", 64'(mem_wr), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
      owner = -1; waited = 0; rr_m1_next = 0;
      p1 = empty_acc; p2 = empty_acc; e_addr = '0; e_wdata = '0;
    end else begin
      mg0 = 0; mg1 = 0;
      if (owner == 0) mg0 = m0_req;
      else if (owner == 1) mg1 = m1_req;
      else begin
`ifdef ARB_RR_EN
        if (m0_req && m1_req) begin mg1 = rr_m1_next; mg0 = !rr_m1_next; end
        else begin mg0 = m0_req; mg1 = m1_req; end
`else
        if (m1_req && (!m0_req || waited == MW)) mg1 = 1;
        else mg0 = m0_req;
`endif
      end
      chk("m0_gnt", 64'(m0_gnt), 64'(mg0));
      chk("m1_gnt", 64'(m1_gnt), 64'(mg1));
      chk("mem_wr", 64'(mem_wr), p1.v ? 64'(p1.wr) : 64'd0);
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      chk("m0_rvalid", 64'(m0_rvalid), 64'(p2.v && !p2.who));
      chk("m1_rvalid", 64'(m1_rvalid), 64'(p2.v && p2.who));
      if (p2.v) begin
        for (int p = 0; p < 3; p++) mask[p*DW +: DW] = p2.wr[p] ? 8'h00 : 8'hFF;
        chk("rdata", 64'((p2.who ? m1_rdata : m0_rdata) & mask), 64'(p2.rd & mask));
      end
      nw = empty_acc;
      if (mg0 || mg1) begin
        nw.v = 1; nw.who = mg1;
        nw.wr = mg1 ? m1_wr : m0_wr;
        nw.addr = mg1 ? m1_addr : m0_addr;
        nw.wdata = mg1 ? m1_wdata : m0_wdata;
        for (int p = 0; p < 3; p++) begin
          if (!nw.wr[p]) nw.rd[p*DW +: DW] = shadow[p][nw.addr[p*AW +: AW]];
          else shadow[p][nw.addr[p*AW +: AW]] = nw.wdata[p*DW +: DW];
        end
        e_addr = nw.addr; e_wdata = nw.wdata;
      end
      p2 = p1; p1 = nw;
      if (owner == 0 && (!m0_req || !m0_lock)) owner = -1;
      else if (owner == 1 && (!m1_req || !m1_lock)) owner = -1;
      else if (owner == -1 && mg0 && m0_lock) owner = 0;
      else if (owner == -1 && mg1 && m1_lock) owner = 1;
      waited = (m1_req && !mg1) ? ((waited < MW) ? waited + 1 : MW) : 0;
      if (mg0) rr_m1_next = 1;
      else if (mg1) rr_m1_next = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_lock = 0; m0_wr = 0;
    m1_req = 0; m1_lock = 0; m1_wr = 0;
  endtask

  task automatic set_m0(input bit req, input bit lock, input logic [2:0] wr,
                        input logic [AW-1:0] a, input logic [7:0] d);
    m0_req = req; m0_lock = lock; m0_wr = wr; m0_addr = {a, a, a}; m0_wdata = {d, d, d};
  endtask

  task automatic set_m1(input bit req, input bit lock, input logic [2:0] wr,
                        input logic [AW-1:0] a, input logic [7:0] d);
    m1_req = req; m1_lock = lock; m1_wr = wr; m1_addr = {a, a, a}; m1_wdata = {d, d, d};
  endtask

  task automatic rand_txn(output logic req, output logic lock, output logic [2:0] wr,
                          output logic [3*AW-1:0] a, output logic [3*DW-1:0] d);
    req = ($urandom_range(99) < 70);
    lock = ($urandom_range(99) < 25);
    wr = 3'($urandom_range(7));
    for (int p = 0; p < 3; p++) begin
      a[p*AW +: AW] = AW'($urandom_range(15));
      d[p*DW +: DW] = 8'($urandom_range(255));
    end
  endtask

  task automatic do_reset();
    reset = 1; idle();
    tick(); tick();
    reset = 0;
  endtask

  int rv_cnt;
  bit gp0, gp1;

  initial begin
    empty_acc = '{v: 0, who: 0, wr: '0, addr: '0, wdata: '0, rd: '0};
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < 16384; a++) begin
        env_mem[p][a] = 8'($urandom_range(255));
        shadow[p][a] = env_mem[p][a];
      end
    end
    #1 reset = 1;
    tick(); tick();
    reset = 0;

    // Write R then read back all planes.
    set_m0(1, 0, 3'b001, 14'h0081, 8'h5A);
    #3 chk("t1_wr_gnt", 64'(m0_gnt), 64'd1);
    tick();
    set_m0(1, 0, 3'b000, 14'h0081, 8'h00);
    #3 chk("t1_rd_gnt", 64'(m0_gnt), 64'd1);
    chk("t1_mem_wr", 64'(mem_wr), 64'b001);
    chk("t1_mem_addr", 64'(mem_addr[AW-1:0]), 64'h0081);
    tick();
    idle();
    tick();
    #3 chk("t1_rvalid", 64'(m0_rvalid), 64'd1);
    chk("t1_rdata", 64'(m0_rdata[7:0]), 64'h5A);
    tick();

    // Both requesting: m1 starves for MAX_WAIT cycles then wins once.
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        set_m0(1, 0, 3'b000, AW'(i), 8'h00);
        set_m1(1, 0, 3'b000, AW'(i + 32), 8'h00);
      end else idle();
      #3;
      if (i < 10) begin
        chk("t2_m1_gnt", 64'(m1_gnt), 64'(i == 8));
        chk("t2_m0_gnt", 64'(m0_gnt), 64'(i != 8));
      end
      if (m1_rvalid) rv_cnt++;
      if (i == 10) chk("t2_m1_rvalid", 64'(m1_rvalid), 64'd1);
      tick();
    end
    chk("t2_rvalid_cnt", 64'(rv_cnt), 64'd1);

    // Locked m0 burst blocks m1 even with the starvation counter saturated.
    for (int i = 0; i < 14; i++) begin
      set_m1(i < 13, 0, 3'b000, 14'h0100, 8'h00);
      set_m0(1, i < 11, 3'b000, AW'(i), 8'h00);
      #3;
      if (i < 12) begin
        chk("t3_m1_blocked", 64'(m1_gnt), 64'd0);
        chk("t3_m0_burst", 64'(m0_gnt), 64'd1);
      end else if (i == 12) begin
        chk("t3_m1_forced", 64'(m1_gnt), 64'd1);
        chk("t3_m0_denied", 64'(m0_gnt), 64'd0);
      end else chk("t3_m0_after", 64'(m0_gnt), 64'd1);
      tick();
    end
    idle(); tick();

    // m1 alone, back-to-back reads.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_m1(1, 0, 3'b000, AW'(i), 8'h00);
      else idle();
      #3;
      if (i < 3) chk("t4_gnt", 64'(m1_gnt), 64'd1);
      if (i >= 1 && i <= 3) chk("t4_addr", 64'(mem_addr[AW-1:0]), 64'(i - 1));
      if (i >= 2 && i <= 4) begin
        chk("t4_m1_rvalid", 64'(m1_rvalid), 64'd1);
        chk("t4_m0_rvalid", 64'(m0_rvalid), 64'd0);
      end
      tick();
    end

    // Reset while m1 owns a locked burst with two reads in flight.
    set_m1(1, 1, 3'b000, 14'h0005, 8'h00);
    #3 chk("t5_gnt_a", 64'(m1_gnt), 64'd1);
    tick();
    set_m1(1, 1, 3'b000, 14'h0006, 8'h00);
    #3 chk("t5_gnt_b", 64'(m1_gnt), 64'd1);
    tick();
    reset = 1;
    #3 chk("t5_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_m1_rvalid", 64'(m1_rvalid), 64'd0);
    tick();
    #3 chk("t5_m1_rvalid2", 64'(m1_rvalid), 64'd0);
    tick();
    reset = 0; idle();
    set_m0(1, 0, 3'b000, 14'h0007, 8'h00);
    #3 chk("t5_m0_gnt", 64'(m0_gnt), 64'd1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #3 chk("t5_no_m1_rvalid", 64'(m1_rvalid), 64'd0);
      tick();
    end

`ifdef ARB_RR_EN
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_m0(1, 0, 3'b000, AW'(i), 8'h00);
      set_m1(1, 0, 3'b000, AW'(i + 64), 8'h00);
      #3 chk("rr_m0", 64'(m0_gnt), 64'(i % 2 == 0));
      chk("rr_m1", 64'(m1_gnt), 64'(i % 2 == 1));
      tick();
    end
    idle(); tick();
`endif

    // Random traffic; a denied request is held unchanged or occasionally withdrawn.
    gp0 = 0; gp1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m0_req && !gp0) begin
        if ($urandom_range(9) == 0) m0_req = 0;
      end else rand_txn(m0_req, m0_lock, m0_wr, m0_addr, m0_wdata);
      if (m1_req && !gp1) begin
        if ($urandom_range(9) == 0) m1_req = 0;
      end else rand_txn(m1_req, m1_lock, m1_wr, m1_addr, m1_wdata);
      #3;
      gp0 = m0_gnt; gp1 = m1_gnt;
      tick();
    end
    idle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
